mod_99_express_rx_filter: RTL and testbench
===========================================

Name: mod_99_express_rx_filter

Overview:
- Synthesizable, clocked successor to the Clause 99 express receive filter.
- Accepts the reassembly-side byte stream from the PHY/RS (rx_dv, byte strobe, data) and classifies each mPacket by its SMD.
- Forwards express frames to the eMAC, rewriting SMD-E to SFD.
- Checks verify/respond mPackets for exact length and mCRC, pulses rcv_v/rcv_r, and keeps statistics counters.

Parameters:
- PREAMBLE_MAX, 7: max 0x55 bytes accepted before an SMD; the next 0x55 beyond this is an error.
- VR_LEN, 64: exact byte count after SMD-V/SMD-R, including the 4-byte mCRC.
- MCRC_XOR, 32'h0000FFFF: XOR applied to the FCS to form the mCRC.
- CHECK_VR_CRC, 1: 1 = V/R requires length and mCRC match; 0 = length only.
- CNT_W, 16: width of the statistics counters.

Ports:
- clk  in  1  block clock.
- reset_begin  in  1  asynchronous, active-high reset.
- rx_dv  in  1  frame in progress from RS.
- rx_byte_valid  in  1  rx_data holds a new byte this cycle.
- rx_data  in  8  received byte.
- e_rx_dv  out  1  express receive data valid to the eMAC.
- e_rx_byte_valid  out  1  e_rx_data valid strobe.
- e_rx_data  out  8  express byte.
- rcv_v  out  1  one-cycle pulse: valid verify mPacket received.
- rcv_r  out  1  one-cycle pulse: valid respond mPacket received.
- smd_err  out  1  one-cycle pulse: unknown SMD or preamble overrun.
- express_cnt  out  CNT_W  express frames completed (saturating).
- vr_err_cnt  out  CNT_W  V/R mPackets failing length or mCRC (saturating).

Behaviour:
- Reset (async): state = INIT. All outputs 0, counters 0, CRC = 32'hFFFFFFFF.
- Bytes are consumed only on cycles with rx_byte_valid = 1.
- All outputs are registered. Express data latency is exactly 1 clk: input byte at cycle n appears on e_rx_data with e_rx_byte_valid at n+1.
- INIT: wait for rx_dv = 0, then go to IDLE. This protects against reset mid-frame.
- IDLE: on rx_dv = 1, go to CHECK and set e_rx_dv = 1 on the next clk. Clear the preamble count, byte count and CRC.
- CHECK, per byte:
  - 0x55 with pre_cnt < PREAMBLE_MAX: forward 0x55, pre_cnt++.
  - 0x55 with pre_cnt = PREAMBLE_MAX: smd_err pulse, go to DISCARD.
  - 0xD5 (SMD-E): forward 0xD5, go to E_DATA.
  - 0x07 (SMD-V): go to VR, latch type = V.
  - 0x19 (SMD-R): go to VR, latch type = R.
  - SMD-S 0xE6/0x4C/0x7F/0xB3 or SMD-C 0x61/0x52/0x9E/0x2A: go to DISCARD, no smd_err (preemptable traffic).
  - Any other value: smd_err pulse, go to DISCARD.
- In the V, R, S, C and error cases above, e_rx_dv drops to 0 in the clk after that byte. The current byte is not forwarded.
- E_DATA: forward every byte. When rx_dv falls: e_rx_dv = 0 next clk, express_cnt++, go to IDLE.
- VR:
  - Count bytes with byte_cnt saturating at VR_LEN+1.
  - Bytes pass through a 4-byte delay line. Only bytes leaving the line are fed to the CRC-32: poly 0x04C11DB7, reflected, LSB-first, init all-ones. The CRC therefore covers all bytes except the last 4.
  - When rx_dv falls, pass requires byte_cnt == VR_LEN.
  - If CHECK_VR_CRC = 1, pass also requires {d3,d2,d1,d0} == (~crc) ^ MCRC_XOR. d0 is the earliest of the last 4 bytes, so byte k maps to bits [8k+7:8k].
  - Pass: pulse rcv_v or rcv_r for 1 clk. Fail: vr_err_cnt++. Either way go to IDLE.
- DISCARD: ignore bytes; when rx_dv falls, go to IDLE.
- rx_dv falling while in CHECK (no SMD yet): e_rx_dv = 0, no counter change, go to IDLE.
- rx_dv falling on the same cycle as a final byte with rx_byte_valid = 1: that byte is processed first, then the end-of-frame action.
- Counters saturate at all-ones and do not wrap.
- rcv_v and rcv_r are never both high.
- reset_begin asserted mid-frame: immediate return to reset values, then INIT.

Test Plan:
- 7×0x55, 0xD5, 46 payload bytes, rx_dv low -> e_rx_data shows 7×0x55, 0xD5 and the payload 1 clk delayed. e_rx_dv falls 1 clk after rx_dv. express_cnt = 1.
- 7×0x55, 0x07, 60×0x00, correct mCRC (FCS^0x0000FFFF) -> e_rx_dv falls after the SMD byte. Single rcv_v pulse. vr_err_cnt = 0.
- Same frame with SMD 0x19 and one mCRC bit flipped -> no rcv_r pulse, vr_err_cnt = 1. Repeat with CHECK_VR_CRC = 0 -> rcv_r pulses.
- 0x07 followed by 63 or 65 bytes -> no rcv_v pulse, vr_err_cnt increments each time.
- 8×0x55 -> smd_err pulse on the 8th byte, no express bytes after it. SMD 0xE6 -> no smd_err, e_rx_dv drops.
- Assert reset_begin mid E_DATA while rx_dv stays high -> outputs 0 immediately. Remaining bytes are ignored until rx_dv low, then the next frame is forwarded normally.

Source files
------------

// File: rtl/mod_99_express_rx_filter.sv
`timescale 1ns/1ps
// Clause 99 express receive filter: classifies mPackets by SMD, forwards express
// frames to the eMAC and validates verify/respond mPackets (length + mCRC).
module mod_99_express_rx_filter #(
    parameter int unsigned PREAMBLE_MAX = 7,
    parameter int unsigned VR_LEN       = 64,
    parameter logic [31:0] MCRC_XOR     = 32'h0000FFFF,
    parameter bit          CHECK_VR_CRC = 1'b1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset_begin,
    input  logic             rx_dv,
    input  logic             rx_byte_valid,
    input  logic [7:0]       rx_data,
    output logic             e_rx_dv,
    output logic             e_rx_byte_valid,
    output logic [7:0]       e_rx_data,
    output logic             rcv_v,
    output logic             rcv_r,
    output logic             smd_err,
    output logic [CNT_W-1:0] express_cnt,
    output logic [CNT_W-1:0] vr_err_cnt
);
    localparam int unsigned    PW    = $clog2(PREAMBLE_MAX + 1);
    localparam int unsigned    BW    = $clog2(VR_LEN + 2);
    localparam logic [PW-1:0]  PMAX  = PW'(PREAMBLE_MAX);
    localparam logic [BW-1:0]  VLEN  = BW'(VR_LEN);
    localparam logic [BW-1:0]  BSAT  = BW'(VR_LEN + 1);

    typedef enum logic [2:0] {
        ST_INIT, ST_IDLE, ST_CHECK, ST_E_DATA, ST_VR, ST_DISCARD
    } state_t;

    state_t         r_state;
    logic [PW-1:0]  r_pre_cnt;
    logic [BW-1:0]  r_byte_cnt;
    logic [31:0]    r_crc;
    logic [31:0]    r_dly;
    logic           r_is_r;

    state_t         w_state;
    logic [PW-1:0]  w_pre_cnt;
    logic [BW-1:0]  w_byte_cnt;
    logic [31:0]    w_crc;
    logic [31:0]    w_dly;
    logic           w_is_r;
    logic           w_fwd;
    logic           w_smd_err;
    logic           w_drop;
    logic           w_vr_pass;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] v;
        v = c ^ {24'h0, b};
        for (int unsigned i = 0; i < 8; i++)
            v = v[0] ? ((v >> 1) ^ 32'hEDB88320) : (v >> 1);
        return v;
    endfunction

    // Byte processing is resolved combinationally so a byte arriving with the
    // falling rx_dv is absorbed before the end-of-frame decision.
    always_comb begin
        w_state    = r_state;
        w_pre_cnt  = r_pre_cnt;
        w_byte_cnt = r_byte_cnt;
        w_crc      = r_crc;
        w_dly      = r_dly;
        w_is_r     = r_is_r;
        w_fwd      = 1'b0;
        w_smd_err  = 1'b0;
        w_drop     = 1'b0;
        if (rx_byte_valid) begin
            case (r_state)
                ST_CHECK: begin
                    case (rx_data)
                        8'h55: begin
                            if (r_pre_cnt == PMAX) begin
                                w_smd_err = 1'b1;
                                w_drop    = 1'b1;
                                w_state   = ST_DISCARD;
                            end else begin
                                w_fwd     = 1'b1;
                                w_pre_cnt = r_pre_cnt + 1'b1;
                            end
                        end
                        8'hD5: begin
                            w_fwd   = 1'b1;
                            w_state = ST_E_DATA;
                        end
                        8'h07, 8'h19: begin
                            w_drop  = 1'b1;
                            w_is_r  = (rx_data == 8'h19);
                            w_state = ST_VR;
                        end
                        8'hE6, 8'h4C, 8'h7F, 8'hB3, 8'h61, 8'h52, 8'h9E, 8'h2A: begin
                            w_drop  = 1'b1;
                            w_state = ST_DISCARD;
                        end
                        default: begin
                            w_smd_err = 1'b1;
                            w_drop    = 1'b1;
                            w_state   = ST_DISCARD;
                        end
                    endcase
                end
                ST_E_DATA: w_fwd = 1'b1;
                ST_VR: begin
                    if (r_byte_cnt != BSAT)
                        w_byte_cnt = r_byte_cnt + 1'b1;
                    if (r_byte_cnt >= BW'(4))
                        w_crc = crc_byte(r_crc, r_dly[7:0]);
                    w_dly = {rx_data, r_dly[31:8]};
                end
                default: ;
            endcase
        end
        w_vr_pass = (w_byte_cnt == VLEN) &&
                    (!CHECK_VR_CRC || (w_dly == ((~w_crc) ^ MCRC_XOR)));
    end

    always_ff @(posedge clk or posedge reset_begin) begin
        if (reset_begin) begin
            r_state         <= ST_INIT;
            r_pre_cnt       <= '0;
            r_byte_cnt      <= '0;
            r_crc           <= '1;
            r_dly           <= '0;
            r_is_r          <= 1'b0;
            e_rx_dv         <= 1'b0;
            e_rx_byte_valid <= 1'b0;
            e_rx_data       <= '0;
            rcv_v           <= 1'b0;
            rcv_r           <= 1'b0;
            smd_err         <= 1'b0;
            express_cnt     <= '0;
            vr_err_cnt      <= '0;
        end else begin
            r_state         <= w_state;
            r_pre_cnt       <= w_pre_cnt;
            r_byte_cnt      <= w_byte_cnt;
            r_crc           <= w_crc;
            r_dly           <= w_dly;
            r_is_r          <= w_is_r;
            e_rx_byte_valid <= w_fwd;
            smd_err         <= w_smd_err;
            rcv_v           <= 1'b0;
            rcv_r           <= 1'b0;
            if (w_fwd)
                e_rx_data <= rx_data;
            if (w_drop)
                e_rx_dv <= 1'b0;
            case (r_state)
                ST_INIT: begin
                    if (!rx_dv)
                        r_state <= ST_IDLE;
                end
                ST_IDLE: begin
                    r_pre_cnt  <= '0;
                    r_byte_cnt <= '0;
                    r_crc      <= '1;
                    r_dly      <= '0;
                    if (rx_dv) begin
                        r_state <= ST_CHECK;
                        e_rx_dv <= 1'b1;
                    end
                end
                default: begin
                    if (!rx_dv) begin
                        r_state <= ST_IDLE;
                        e_rx_dv <= 1'b0;
                        if (w_state == ST_E_DATA && express_cnt != '1)
                            express_cnt <= express_cnt + 1'b1;
                        if (w_state == ST_VR) begin
                            if (w_vr_pass) begin
                                rcv_v <= !w_is_r;
                                rcv_r <= w_is_r;
                            end else if (vr_err_cnt != '1) begin
                                vr_err_cnt <= vr_err_cnt + 1'b1;
                            end
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mod_99_express_rx_filter.sv
`timescale 1ns/1ps
// Directed bench for the express receive filter: table vectors for SMD
// classification plus hand-built express, verify/respond and reset sequences.
module tb_mod_99_express_rx_filter;
    logic       clk = 1'b0;
    logic       rst;
    logic       rx_dv, rx_byte_valid;
    logic [7:0] rx_data;

    logic       e_rx_dv, e_rx_byte_valid, rcv_v, rcv_r, smd_err;
    logic [7:0] e_rx_data;
    logic [15:0] express_cnt, vr_err_cnt;

    logic       e_rx_dv_1, e_rx_byte_valid_1, rcv_v_1, rcv_r_1, smd_err_1;
    logic [7:0] e_rx_data_1;
    logic [1:0] express_cnt_1, vr_err_cnt_1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mod_99_express_rx_filter dut (
        .clk(clk), .reset_begin(rst), .rx_dv(rx_dv), .rx_byte_valid(rx_byte_valid),
        .rx_data(rx_data), .e_rx_dv(e_rx_dv), .e_rx_byte_valid(e_rx_byte_valid),
        .e_rx_data(e_rx_data), .rcv_v(rcv_v), .rcv_r(rcv_r), .smd_err(smd_err),
        .express_cnt(express_cnt), .vr_err_cnt(vr_err_cnt)
    );

    // Length-only V/R checking with 2-bit counters, to observe saturation.
    mod_99_express_rx_filter #(.CHECK_VR_CRC(1'b0), .CNT_W(2)) dut_lo (
        .clk(clk), .reset_begin(rst), .rx_dv(rx_dv), .rx_byte_valid(rx_byte_valid),
        .rx_data(rx_data), .e_rx_dv(e_rx_dv_1), .e_rx_byte_valid(e_rx_byte_valid_1),
        .e_rx_data(e_rx_data_1), .rcv_v(rcv_v_1), .rcv_r(rcv_r_1), .smd_err(smd_err_1),
        .express_cnt(express_cnt_1), .vr_err_cnt(vr_err_cnt_1)
    );

    typedef struct {
        logic       dv;
        logic       bv;
        logic [7:0] d;
        logic       x_edv;
        logic       x_ebv;
        logic [7:0] x_dat;
        logic       x_serr;
    } vec_t;

    vec_t       tbl[$];
    logic [7:0] fq[$];
    logic [7:0] xq[$];
    logic [7:0] cap[$];
    logic       edvh[$];
    int nv0, nr0, ns0, nv1, nr1, both_hi;

    function automatic vec_t mk(input logic dv, bv, input logic [7:0] d,
                                input logic xedv, xebv, input logic [7:0] xd, input logic xs);
        vec_t v;
        v.dv = dv; v.bv = bv; v.d = d;
        v.x_edv = xedv; v.x_ebv = xebv; v.x_dat = xd; v.x_serr = xs;
        return v;
    endfunction

    function automatic logic [31:0] ref_crc(input int n);
        logic [31:0] c;
        logic fb;
        c = 32'hFFFFFFFF;
        for (int k = 0; k < n; k++)
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ fq[8 + k][b];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB88320;
            end
        return c;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input logic dv, input logic bv, input logic [7:0] d);
        rx_dv = dv; rx_byte_valid = bv; rx_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic rec();
        edvh.push_back(e_rx_dv);
        if (e_rx_byte_valid) cap.push_back(e_rx_data);
        nv0 += int'(rcv_v); nr0 += int'(rcv_r); ns0 += int'(smd_err);
        nv1 += int'(rcv_v_1); nr1 += int'(rcv_r_1);
        if ((rcv_v && rcv_r) || (rcv_v_1 && rcv_r_1)) both_hi++;
    endtask

    task automatic send_frame();
        cap.delete(); edvh.delete();
        nv0 = 0; nr0 = 0; ns0 = 0; nv1 = 0; nr1 = 0;
        step(1'b1, 1'b0, 8'h00); rec();
        foreach (fq[i]) begin step(1'b1, 1'b1, fq[i]); rec(); end
        step(1'b0, 1'b0, 8'h00); rec();
        step(1'b0, 1'b0, 8'h00); rec();
    endtask

    task automatic cmp_cap(input string nm);
        int nbad;
        nbad = 0;
        chk({nm, "_len"}, cap.size(), xq.size());
        foreach (xq[i]) if (i >= cap.size() || cap[i] !== xq[i]) nbad++;
        chk({nm, "_data"}, nbad, 0);
    endtask

    task automatic build_vr(input logic [7:0] smd, input int npay, input bit good_crc);
        logic [31:0] m;
        fq.delete(); xq.delete();
        repeat (7) begin fq.push_back(8'h55); xq.push_back(8'h55); end
        fq.push_back(smd);
        repeat (npay) fq.push_back(8'h00);
        if (good_crc) begin
            m = (~ref_crc(npay)) ^ 32'h0000FFFF;
            fq.push_back(m[7:0]); fq.push_back(m[15:8]);
            fq.push_back(m[23:16]); fq.push_back(m[31:24]);
        end
    endtask

    initial begin
        #1ms;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        both_hi = 0;
        tbl.push_back(mk(0,0,8'h00, 0,0,8'h00,0));
        tbl.push_back(mk(1,0,8'h00, 1,0,8'h00,0));
        for (int i = 0; i < 7; i++) tbl.push_back(mk(1,1,8'h55, 1,1,8'h55,0));
        tbl.push_back(mk(1,1,8'h55, 0,0,8'h00,1));
        tbl.push_back(mk(1,1,8'hD5, 0,0,8'h00,0));
        tbl.push_back(mk(0,0,8'h00, 0,0,8'h00,0));
        tbl.push_back(mk(1,0,8'h00, 1,0,8'h00,0));
        tbl.push_back(mk(1,1,8'h55, 1,1,8'h55,0));
        tbl.push_back(mk(1,1,8'hE6, 0,0,8'h00,0));
        tbl.push_back(mk(1,1,8'hAA, 0,0,8'h00,0));
        tbl.push_back(mk(0,0,8'h00, 0,0,8'h00,0));
        tbl.push_back(mk(1,0,8'h00, 1,0,8'h00,0));
        tbl.push_back(mk(1,1,8'h33, 0,0,8'h00,1));
        tbl.push_back(mk(0,0,8'h00, 0,0,8'h00,0));
        tbl.push_back(mk(1,0,8'h00, 1,0,8'h00,0));
        tbl.push_back(mk(1,1,8'h55, 1,1,8'h55,0));
        tbl.push_back(mk(1,0,8'h00, 1,0,8'h00,0));
        tbl.push_back(mk(0,0,8'h00, 0,0,8'h00,0));
        tbl.push_back(mk(1,0,8'h00, 1,0,8'h00,0));
        tbl.push_back(mk(1,1,8'hD5, 1,1,8'hD5,0));
        tbl.push_back(mk(1,1,8'h12, 1,1,8'h12,0));
        tbl.push_back(mk(0,1,8'h34, 0,1,8'h34,0));
        tbl.push_back(mk(0,0,8'h00, 0,0,8'h00,0));

        rst = 1'b1; rx_dv = 1'b0; rx_byte_valid = 1'b0; rx_data = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_outs", {e_rx_dv, e_rx_byte_valid, e_rx_data, rcv_v, rcv_r, smd_err}, 32'h0);
        chk("reset_cnts", {express_cnt, vr_err_cnt}, 32'h0);

        foreach (tbl[i]) begin
            step(tbl[i].dv, tbl[i].bv, tbl[i].d);
            chk($sformatf("vec[%0d]", i),
                {e_rx_dv, e_rx_byte_valid, (tbl[i].x_ebv ? e_rx_data : 8'h00), smd_err},
                {tbl[i].x_edv, tbl[i].x_ebv, tbl[i].x_dat, tbl[i].x_serr});
        end
        chk("tbl_express_cnt", express_cnt, 1);
        chk("tbl_vr_err_cnt", vr_err_cnt, 0);

        // Express frame: full preamble, SFD and 46 payload bytes.
        fq.delete();
        repeat (7) fq.push_back(8'h55);
        fq.push_back(8'hD5);
        for (int i = 0; i < 46; i++) fq.push_back(8'(i * 7 + 3));
        xq = fq;
        send_frame();
        cmp_cap("E");
        chk("E_edv_last", edvh[54], 1);
        chk("E_edv_fall", edvh[55], 0);
        chk("E_express_cnt", express_cnt, 2);
        chk("E_express_cnt_lo", express_cnt_1, 2);

        build_vr(8'h07, 60, 1'b1);
        send_frame();
        cmp_cap("V");
        chk("V_edv_pre", edvh[7], 1);
        chk("V_edv_smd", edvh[8], 0);
        chk("V_rcv_v", nv0, 1);
        chk("V_rcv_r", nr0, 0);
        chk("V_smd_err", ns0, 0);
        chk("V_vr_err", vr_err_cnt, 0);
        chk("V_rcv_v_lo", nv1, 1);

        build_vr(8'h19, 60, 1'b1);
        fq[68] = fq[68] ^ 8'h01;
        send_frame();
        chk("Rbad_rcv_r", nr0, 0);
        chk("Rbad_rcv_v", nv0, 0);
        chk("Rbad_vr_err", vr_err_cnt, 1);
        chk("Rbad_rcv_r_lo", nr1, 1);
        chk("Rbad_vr_err_lo", vr_err_cnt_1, 0);

        build_vr(8'h07, 63, 1'b0);
        send_frame();
        chk("L63_rcv_v", nv0 + nv1, 0);
        chk("L63_vr_err", vr_err_cnt, 2);
        chk("L63_vr_err_lo", vr_err_cnt_1, 1);

        build_vr(8'h07, 65, 1'b0);
        send_frame();
        chk("L65_rcv_v", nv0 + nv1, 0);
        chk("L65_vr_err", vr_err_cnt, 3);
        chk("L65_vr_err_lo", vr_err_cnt_1, 2);

        fq.delete();
        fq.push_back(8'h55); fq.push_back(8'hD5); fq.push_back(8'h01); fq.push_back(8'h02);
        send_frame();
        send_frame();
        chk("sat_express_cnt", express_cnt, 4);
        chk("sat_express_cnt_lo", express_cnt_1, 3);

        build_vr(8'h07, 10, 1'b0);
        send_frame();
        send_frame();
        chk("sat_vr_err", vr_err_cnt, 5);
        chk("sat_vr_err_lo", vr_err_cnt_1, 3);
        chk("never_both_rcv", both_hi, 0);

        // Reset in the middle of an express frame with rx_dv held high.
        step(1'b1, 1'b0, 8'h00);
        repeat (7) step(1'b1, 1'b1, 8'h55);
        step(1'b1, 1'b1, 8'hD5);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 8'(8'h20 + i));
        #3 rst = 1'b1;
        #1;
        chk("midrst_outs", {e_rx_dv, e_rx_byte_valid, e_rx_data, rcv_v, rcv_r, smd_err}, 32'h0);
        chk("midrst_cnts", {express_cnt, vr_err_cnt}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        cap.delete(); edvh.delete();
        for (int i = 0; i < 10; i++) begin step(1'b1, 1'b1, 8'(8'h40 + i)); rec(); end
        chk("midrst_ignored_bytes", cap.size(), 0);
        chk("midrst_edv_high", edvh.sum() with (int'(item)), 0);
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        fq.delete();
        fq.push_back(8'h55); fq.push_back(8'hD5);
        fq.push_back(8'hA1); fq.push_back(8'hA2); fq.push_back(8'hA3);
        xq = fq;
        send_frame();
        cmp_cap("post_rst");
        chk("post_rst_express_cnt", express_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
